// File: rtl/spec_free_list_pkg.sv
// Shared sizes, tag typedefs and a 4-bit population count for the speculative free list.
package spec_free_list_pkg;

  localparam int unsigned SIZE_PHYSICAL_TABLE = 96;
  localparam int unsigned SIZE_PHYSICAL_LOG   = 7;
  localparam int unsigned SIZE_RMT            = 32;
  localparam int unsigned SIZE_FREE_LIST      = SIZE_PHYSICAL_TABLE - SIZE_RMT;
  localparam int unsigned SIZE_FREE_LIST_LOG  = 6;
  localparam int unsigned FL_CNT_W            = SIZE_FREE_LIST_LOG + 1;
  localparam int unsigned FL_PORTS            = 4;

  typedef logic [SIZE_PHYSICAL_LOG-1:0]  phys_tag_t;
  typedef logic [SIZE_FREE_LIST_LOG-1:0] fl_ptr_t;
  typedef logic [FL_CNT_W-1:0]           fl_cnt_t;

  function automatic logic [2:0] pop_count4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/spec_free_list_compact.sv
// Release-side compaction: per-slot write offset (valid slots packed from 0) and push count.
module spec_free_list_compact
  import spec_free_list_pkg::*;
(
  input  logic [3:0]      i_valid,
  output logic [3:0][1:0] o_offset_c,
  output logic [2:0]      o_push_cnt_c
);

  assign o_offset_c[0] = 2'd0;
  assign o_offset_c[1] = 2'(i_valid[0]);
  assign o_offset_c[2] = 2'(i_valid[0]) + 2'(i_valid[1]);
  assign o_offset_c[3] = 2'(i_valid[0]) + 2'(i_valid[1]) + 2'(i_valid[2]);
  assign o_push_cnt_c  = pop_count4(i_valid);

endmodule

// File: rtl/spec_free_list.sv
// Speculative rename free list: 4 pops/cycle at head, 4 commit pushes/cycle at tail, snap-back on recovery.
// Optional FREE_LIST_CHECK_EN adds flErr_o, overflow saturation and request-contiguity assertions.
module spec_free_list
  import spec_free_list_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         reqValid0_i,
  input  logic                         reqValid1_i,
  input  logic                         reqValid2_i,
  input  logic                         reqValid3_i,
  output logic [SIZE_PHYSICAL_LOG-1:0] freeReg0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freeReg1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freeReg2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freeReg3_o,
  output logic                         freeListEmpty_o,
  input  logic                         releasedValid0_i,
  input  logic                         releasedValid1_i,
  input  logic                         releasedValid2_i,
  input  logic                         releasedValid3_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] releasedPhyMap0_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] releasedPhyMap1_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] releasedPhyMap2_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] releasedPhyMap3_i,
  input  logic                         recoverFlag_i
`ifdef FREE_LIST_CHECK_EN
  ,
  output logic                         flErr_o
`endif
);

  phys_tag_t r_list [SIZE_FREE_LIST];
  fl_ptr_t   r_head_ptr;
  fl_ptr_t   r_tail_ptr;
  fl_cnt_t   r_free_cnt;
  logic      r_empty;

  logic [3:0]      w_req;
  logic [3:0]      w_rel_valid;
  phys_tag_t       w_rel_tag [FL_PORTS];
  logic [3:0][1:0] w_offset;
  logic [2:0]      w_push_cnt;
  logic [2:0]      w_push_acc;
  logic [2:0]      w_pop_cnt;
  logic [2:0]      w_pop_apl;
  logic            w_pop_en;
  logic [3:0]      w_wr_en;
  fl_ptr_t         w_tail_next;
  fl_ptr_t         w_head_next;
  fl_cnt_t         w_cnt_next;

  assign w_req       = {reqValid3_i, reqValid2_i, reqValid1_i, reqValid0_i};
  assign w_rel_valid = {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i};
  assign w_rel_tag[0] = releasedPhyMap0_i;
  assign w_rel_tag[1] = releasedPhyMap1_i;
  assign w_rel_tag[2] = releasedPhyMap2_i;
  assign w_rel_tag[3] = releasedPhyMap3_i;

  spec_free_list_compact u_compact (
    .i_valid      (w_rel_valid),
    .o_offset_c   (w_offset),
    .o_push_cnt_c (w_push_cnt)
  );

  // Pops are only honoured when rename is not stalled and no recovery is in flight
  assign w_pop_cnt = pop_count4(w_req);
  assign w_pop_en  = !r_empty && !recoverFlag_i;
  assign w_pop_apl = w_pop_en ? w_pop_cnt : 3'd0;

`ifdef FREE_LIST_CHECK_EN
  logic w_overflow;
  logic w_underflow;
  logic r_fl_err;

  always_comb begin
    w_overflow  = 1'b0;
    w_underflow = FL_CNT_W'(w_pop_apl) > r_free_cnt;
    w_push_acc  = w_push_cnt;
    // Keep only the pushes that fit; the counter then lands exactly on a full list
    if (!recoverFlag_i && !w_underflow &&
        (8'(r_free_cnt) + 8'(w_push_cnt) - 8'(w_pop_apl) > 8'(SIZE_FREE_LIST))) begin
      w_overflow = 1'b1;
      w_push_acc = 3'(8'(SIZE_FREE_LIST) + 8'(w_pop_apl) - 8'(r_free_cnt));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fl_err <= 1'b0;
    else       r_fl_err <= r_fl_err | w_overflow | w_underflow;
  end

  assign flErr_o = r_fl_err;

  a_req_contig: assert property (@(posedge clk) disable iff (reset)
    ((w_req & (w_req + 4'd1)) == 4'd0));
`else
  assign w_push_acc = w_push_cnt;
`endif

  always_comb begin
    for (int s = 0; s < FL_PORTS; s++) begin
      w_wr_en[s] = w_rel_valid[s] && (3'(w_offset[s]) < w_push_acc);
    end
  end

  // Recovery snaps head onto the post-push tail: everything between them is free again
  assign w_tail_next = r_tail_ptr + SIZE_FREE_LIST_LOG'(w_push_acc);
  assign w_head_next = recoverFlag_i ? w_tail_next : r_head_ptr + SIZE_FREE_LIST_LOG'(w_pop_apl);
  assign w_cnt_next  = recoverFlag_i ? FL_CNT_W'(SIZE_FREE_LIST)
                                     : r_free_cnt + FL_CNT_W'(w_push_acc) - FL_CNT_W'(w_pop_apl);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SIZE_FREE_LIST; i++) begin
        r_list[i] <= SIZE_PHYSICAL_LOG'(SIZE_RMT + 32'(i));
      end
    end else begin
      for (int s = 0; s < FL_PORTS; s++) begin
        if (w_wr_en[s]) r_list[r_tail_ptr + SIZE_FREE_LIST_LOG'(w_offset[s])] <= w_rel_tag[s];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head_ptr <= '0;
      r_tail_ptr <= '0;
      r_free_cnt <= FL_CNT_W'(SIZE_FREE_LIST);
      r_empty    <= 1'b0;
    end else begin
      r_head_ptr <= w_head_next;
      r_tail_ptr <= w_tail_next;
      r_free_cnt <= w_cnt_next;
      r_empty    <= w_cnt_next < FL_CNT_W'(FL_PORTS);
    end
  end

  assign freeListEmpty_o = r_empty;
  assign freeReg0_o      = r_list[r_head_ptr];
  assign freeReg1_o      = r_list[r_head_ptr + SIZE_FREE_LIST_LOG'(1)];
  assign freeReg2_o      = r_list[r_head_ptr + SIZE_FREE_LIST_LOG'(2)];
  assign freeReg3_o      = r_list[r_head_ptr + SIZE_FREE_LIST_LOG'(3)];

endmodule
